// File: rtl/gol_vram_if.sv
// CPU-side bus of the Game-of-Life cell memory: cell access plus swap/clear control.
interface gol_vram_if #(
  parameter int CPU_AW = 9
) ();
  logic [CPU_AW-1:0] cpu_addr;
  logic              cpu_we;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              swap_req;
  logic              clear_req;
  logic              busy;
  logic              swap_done;

  modport master (
    output cpu_addr, cpu_we, cpu_wdata, swap_req, clear_req,
    input  cpu_rdata, busy, swap_done
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_wdata, swap_req, clear_req,
    output cpu_rdata, busy, swap_done
  );
endinterface

// File: rtl/gol_vram.sv
// Double-buffered 20x15 byte cell memory; VGA reads the front bank, CPU writes the back bank.
// Optional GOL_VRAM_FRAME_CNT_EN adds frame_cnt and swap_pending_frames counters.
//
// state     | meaning
// IDLE      | accepting clear_req / swap_req
// CLEAR     | zeroing the back bank, one cell per cycle
// SWAP_WAIT | swap requested, waiting for the vsync falling edge
module gol_vram #(
  parameter int COLS   = 20,
  parameter int ROWS   = 15,
  parameter int CPU_AW = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] vaddr,
  output logic [7:0]  vdata,
  input  logic        vga_vs_n,
  gol_vram_if.slave   cpu
`ifdef GOL_VRAM_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  swap_pending_frames
`endif
);

  localparam int                CELLS    = COLS * ROWS;
  localparam logic [CPU_AW-1:0] CELLS_A  = CPU_AW'(CELLS);
  localparam logic [CPU_AW-1:0] LAST_A   = CPU_AW'(CELLS - 1);
  localparam logic [17:0]       CELLS_V  = 18'(CELLS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        bank0 [CELLS];
  logic [7:0]        bank1 [CELLS];
  logic              sel;
  logic [CPU_AW-1:0] clr_ptr;
  logic              vs_d;
  logic              fstart;
  logic              swap_fire;
  logic              mem_we;
  logic [CPU_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [CPU_AW-1:0] vidx;

  assign fstart    = vs_d & ~vga_vs_n;
  assign swap_fire = (state == SWAP_WAIT) && fstart;
  assign vidx      = vaddr[CPU_AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu.clear_req)     state_nxt = CLEAR;
        else if (cpu.swap_req) state_nxt = SWAP_WAIT;
      end
      CLEAR:     if (clr_ptr == LAST_A) state_nxt = IDLE;
      SWAP_WAIT: if (fstart)            state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // The clear sweep owns the write port; CPU writes only land outside CLEAR.
  always_comb begin
    cpu.busy  = (state != IDLE);
    mem_we    = 1'b0;
    mem_addr  = cpu.cpu_addr;
    mem_wdata = cpu.cpu_wdata;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = 8'h00;
      end else if (cpu.cpu_we && (cpu.cpu_addr < CELLS_A)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel           <= 1'b0;
      clr_ptr       <= '0;
      vs_d          <= 1'b1;
      cpu.swap_done <= 1'b0;
    end else begin
      vs_d          <= vga_vs_n;
      sel           <= sel ^ swap_fire;
      cpu.swap_done <= swap_fire;
      if ((state == IDLE) && cpu.clear_req) clr_ptr <= '0;
      else if (state == CLEAR)              clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (sel) bank0[mem_addr] <= mem_wdata;
      else     bank1[mem_addr] <= mem_wdata;
    end
  end

  // Read ports see the pre-toggle sel in the swap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vdata         <= 8'h00;
      cpu.cpu_rdata <= 8'h00;
    end else begin
      if (vaddr < CELLS_V) vdata <= sel ? bank1[vidx] : bank0[vidx];
      else                 vdata <= 8'h00;
      if (cpu.cpu_addr < CELLS_A)
        cpu.cpu_rdata <= sel ? bank1[cpu.cpu_addr] : bank0[cpu.cpu_addr];
      else
        cpu.cpu_rdata <= 8'h00;
    end
  end

`ifdef GOL_VRAM_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt           <= 16'h0000;
      swap_pending_frames <= 8'h00;
    end else begin
      if (fstart) frame_cnt <= frame_cnt + 16'h0001;
      if ((state == IDLE) && !cpu.clear_req && cpu.swap_req)
        swap_pending_frames <= 8'h00;
      else if (swap_fire || ((state == SWAP_WAIT) && fstart)) begin
        if (swap_pending_frames != 8'hFF)
          swap_pending_frames <= swap_pending_frames + 8'h01;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gol_vram.sv
// Self-checking bench for gol_vram: randomized traffic against a two-bank array model.
module tb_gol_vram;
  localparam int CELLS = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] vaddr;
  logic [7:0]  vdata;
  logic        vga_vs_n;
`ifdef GOL_VRAM_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  swap_pending_frames;
`endif

  gol_vram_if #(.CPU_AW(9)) bus ();

  gol_vram dut (
    .clk      (clk),
    .reset    (reset),
    .vaddr    (vaddr),
    .vdata    (vdata),
    .vga_vs_n (vga_vs_n),
    .cpu      (bus)
`ifdef GOL_VRAM_FRAME_CNT_EN
    ,
    .frame_cnt           (frame_cnt),
    .swap_pending_frames (swap_pending_frames)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mbank [2][CELLS];
  int         msel;
  logic [7:0] rd_cpu [CELLS];
  logic [7:0] rd_vga [CELLS];
  int         checks = 0;
  int         errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_write(input int a, input logic [7:0] d);
    bus.cpu_addr  = 9'(a);
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    tick();
    bus.cpu_we    = 1'b0;
    if (a < CELLS) mbank[1 - msel][a] = d;
  endtask

  task automatic swap_and_count(output int pulses);
    pulses = 0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    vga_vs_n = 1'b0;
    tick();
    if (bus.swap_done === 1'b1) pulses++;
    vga_vs_n = 1'b1;
    repeat (3) begin
      tick();
      if (bus.swap_done === 1'b1) pulses++;
    end
  endtask

  task automatic scan_front();
    for (int i = 0; i < CELLS; i++) begin
      bus.cpu_addr = 9'(i);
      vaddr        = 18'(i);
      tick();
      rd_cpu[i] = bus.cpu_rdata;
      rd_vga[i] = vdata;
    end
  endtask

  task automatic count_busy(input logic wr_noise, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      if (wr_noise) begin
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 9'($urandom_range(0, CELLS - 1));
        bus.cpu_wdata = 8'($urandom_range(1, 255));
      end
      tick();
    end
    bus.cpu_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    msel  = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (vdata !== 8'h00 || bus.cpu_rdata !== 8'h00 || bus.busy !== 1'b0 || bus.swap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: vdata=%h rdata=%h busy=%b swap_done=%b, required 00 00 0 0",
               vdata, bus.cpu_rdata, bus.busy, bus.swap_done);
    end
    reset = 1'b0;
    msel  = 0;
    tick();
  endtask

  task automatic test_init_fill();
    int p;
    for (int i = 0; i < CELLS; i++) cpu_write(i, 8'($urandom));
    swap_and_count(p);
    msel = 1 - msel;
    for (int i = 0; i < CELLS; i++) cpu_write(i, 8'($urandom));
    scan_front();
    for (int i = 0; i < CELLS; i++) begin
      checks++;
      if (rd_cpu[i] !== mbank[msel][i] || rd_vga[i] !== mbank[msel][i]) begin
        errors++;
        $display("FAIL init_front[%0d]: cpu=%h vga=%h, required %h", i, rd_cpu[i], rd_vga[i], mbank[msel][i]);
      end
    end
  endtask

  task automatic test_basic_swap();
    int p;
    cpu_write(21, 8'hFF);
    swap_and_count(p);
    msel = 1 - msel;
    checks++;
    if (p !== 1) begin
      errors++;
      $display("FAIL basic_swap_done: pulses=%0d, required 1", p);
    end
    vaddr        = 18'd21;
    bus.cpu_addr = 9'd21;
    tick();
    checks++;
    if (vdata !== 8'hFF || bus.cpu_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL basic_swap_read: vdata=%h rdata=%h, required ff ff", vdata, bus.cpu_rdata);
    end
  endtask

  task automatic test_swap_wait_long();
    int         a, bad_busy, bad_rd;
    logic [7:0] d;
    a = $urandom_range(0, CELLS - 1);
    bad_busy = 0;
    bad_rd   = 0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.cpu_addr = 9'(a);
    repeat (1000) begin
      tick();
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.cpu_rdata !== mbank[msel][a]) bad_rd++;
    end
    checks++;
    if (bad_busy != 0 || bad_rd != 0) begin
      errors++;
      $display("FAIL swap_wait_hold: busy_low=%0d front_changed=%0d, required 0 0", bad_busy, bad_rd);
    end
    d = 8'($urandom);
    vga_vs_n      = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = d;
    tick();
    bus.cpu_we = 1'b0;
    checks++;
    if (bus.swap_done !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_rdata !== mbank[msel][a]) begin
      errors++;
      $display("FAIL swap_edge: swap_done=%b busy=%b rdata=%h, required 1 0 %h",
               bus.swap_done, bus.busy, bus.cpu_rdata, mbank[msel][a]);
    end
    mbank[1 - msel][a] = d;
    msel     = 1 - msel;
    vga_vs_n = 1'b1;
    tick();
    checks++;
    if (bus.swap_done !== 1'b0 || bus.cpu_rdata !== d) begin
      errors++;
      $display("FAIL swap_after: swap_done=%b rdata=%h, required 0 %h", bus.swap_done, bus.cpu_rdata, d);
    end
  endtask

  task automatic test_clear();
    int n, p;
    for (int i = 0; i < CELLS; i++) cpu_write(i, 8'h01);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    count_busy(1'b1, n);
    checks++;
    if (n !== CELLS) begin
      errors++;
      $display("FAIL clear_busy_len: cycles=%0d, required %0d", n, CELLS);
    end
    for (int i = 0; i < CELLS; i++) mbank[1 - msel][i] = 8'h00;
    swap_and_count(p);
    msel = 1 - msel;
    checks++;
    if (p !== 1) begin
      errors++;
      $display("FAIL clear_swap_done: pulses=%0d, required 1", p);
    end
    scan_front();
    for (int i = 0; i < CELLS; i++) begin
      checks++;
      if (rd_cpu[i] !== 8'h00 || rd_vga[i] !== 8'h00) begin
        errors++;
        $display("FAIL clear_zero[%0d]: cpu=%h vga=%h, required 00", i, rd_cpu[i], rd_vga[i]);
      end
    end
  endtask

  task automatic test_clear_swap_same();
    int n, p;
    bus.clear_req = 1'b1;
    bus.swap_req  = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    bus.swap_req  = 1'b0;
    count_busy(1'b0, n);
    checks++;
    if (n !== CELLS) begin
      errors++;
      $display("FAIL clear_wins_len: cycles=%0d, required %0d", n, CELLS);
    end
    for (int i = 0; i < CELLS; i++) mbank[1 - msel][i] = 8'h00;
    p = 0;
    repeat (2) begin
      vga_vs_n = 1'b0;
      tick();
      if (bus.swap_done === 1'b1) p++;
      vga_vs_n = 1'b1;
      tick();
      if (bus.swap_done === 1'b1) p++;
    end
    checks++;
    if (p !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins_noswap: pulses=%0d busy=%b, required 0 0", p, bus.busy);
    end
    scan_front();
    for (int i = 0; i < CELLS; i++) begin
      checks++;
      if (rd_cpu[i] !== mbank[msel][i]) begin
        errors++;
        $display("FAIL clear_wins_front[%0d]: cpu=%h, required %h", i, rd_cpu[i], mbank[msel][i]);
      end
    end
  endtask

  task automatic test_bounds();
    int p;
    vaddr = 18'd300;
    tick();
    checks++;
    if (vdata !== 8'h00) begin
      errors++;
      $display("FAIL vaddr_300: vdata=%h, required 00", vdata);
    end
    vaddr = 18'h3FFFF;
    tick();
    checks++;
    if (vdata !== 8'h00) begin
      errors++;
      $display("FAIL vaddr_max: vdata=%h, required 00", vdata);
    end
    bus.cpu_addr = 9'd511;
    tick();
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL cpu_addr_511: rdata=%h, required 00", bus.cpu_rdata);
    end
    cpu_write(400, 8'hA5);
    cpu_write(300, 8'h5A);
    for (int k = 0; k < 2; k++) begin
      scan_front();
      for (int i = 0; i < CELLS; i++) begin
        checks++;
        if (rd_cpu[i] !== mbank[msel][i] || rd_vga[i] !== mbank[msel][i]) begin
          errors++;
          $display("FAIL oob_write[%0d][%0d]: cpu=%h vga=%h, required %h", k, i, rd_cpu[i], rd_vga[i], mbank[msel][i]);
        end
      end
      swap_and_count(p);
      msel = 1 - msel;
    end
  endtask

  task automatic test_random();
    int op, a, p;
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        cpu_write($urandom_range(0, 330), 8'($urandom));
      end else if (op < 6) begin
        a = $urandom_range(0, 320);
        bus.cpu_addr = 9'(a);
        tick();
        checks++;
        if (bus.cpu_rdata !== ((a < CELLS) ? mbank[msel][a] : 8'h00)) begin
          errors++;
          $display("FAIL rand_cpu_rd[%0d]: rdata=%h, required %h", a, bus.cpu_rdata,
                   (a < CELLS) ? mbank[msel][a] : 8'h00);
        end
      end else if (op < 9) begin
        a = $urandom_range(0, 320);
        vaddr = 18'(a);
        tick();
        checks++;
        if (vdata !== ((a < CELLS) ? mbank[msel][a] : 8'h00)) begin
          errors++;
          $display("FAIL rand_vga_rd[%0d]: vdata=%h, required %h", a, vdata,
                   (a < CELLS) ? mbank[msel][a] : 8'h00);
        end
      end else begin
        swap_and_count(p);
        msel = 1 - msel;
        checks++;
        if (p !== 1) begin
          errors++;
          $display("FAIL rand_swap: pulses=%0d, required 1", p);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int p;
    if (msel == 0) begin
      swap_and_count(p);
      msel = 1;
    end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    repeat (5) tick();
    do_reset();
    p = 0;
    vga_vs_n = 1'b0;
    tick();
    if (bus.swap_done === 1'b1) p++;
    vga_vs_n = 1'b1;
    repeat (2) begin
      tick();
      if (bus.swap_done === 1'b1) p++;
    end
    checks++;
    if (p !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_swap: pulses=%0d busy=%b, required 0 0", p, bus.busy);
    end
    scan_front();
    for (int i = 0; i < CELLS; i++) begin
      checks++;
      if (rd_cpu[i] !== mbank[0][i]) begin
        errors++;
        $display("FAIL reset_sel0[%0d]: cpu=%h, required %h", i, rd_cpu[i], mbank[0][i]);
      end
    end
  endtask

`ifdef GOL_VRAM_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int p;
    do_reset();
    repeat (3) begin
      vga_vs_n = 1'b0;
      repeat (2) tick();
      vga_vs_n = 1'b1;
      repeat (2) tick();
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt: got %0d, required 3", frame_cnt);
    end
    swap_and_count(p);
    msel = 1 - msel;
    checks++;
    if (frame_cnt !== 16'd4 || swap_pending_frames !== 8'd1) begin
      errors++;
      $display("FAIL swap_pending: frame_cnt=%0d pending=%0d, required 4 1", frame_cnt, swap_pending_frames);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    vaddr         = 18'd300;
    vga_vs_n      = 1'b1;
    bus.cpu_addr  = 9'd300;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = 8'h00;
    bus.swap_req  = 1'b0;
    bus.clear_req = 1'b0;
    msel          = 0;
    test_reset();
    test_init_fill();
    test_basic_swap();
    test_swap_wait_long();
    test_clear();
    test_clear_swap_same();
    test_bounds();
    test_random();
    test_reset_mid();
`ifdef GOL_VRAM_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
